// File: rtl/spipass_pkg.sv
// Shared constants and types for the serial byte receiver.
package spipass_pkg;

  localparam int BYTE_W = 8;
  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small byte FIFO with a registered head output; pointers carry an extra wrap bit.
module sync_fifo
  import spipass_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              empty,
  output logic              dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [BYTE_W-1:0] rd_data_q, rd_data_d;
  logic              full;
  logic              pop;
  logic              push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign push    = wr_en && (!full || pop);
  assign dropped = wr_en && full && !pop;
  assign rd_data = rd_data_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
    rd_data_d = rd_data_q;
    // Head register follows the new read pointer; bypass the write when it becomes the head.
    if (push && (rd_ptr_d == wr_ptr_q)) begin
      rd_data_d = wr_data;
    end else if (rd_ptr_d != wr_ptr_q) begin
      rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/serial_byte_rx.sv
// Oversampling receiver for the sclk/sdata/cs_n byte stream: deserializes MSB first,
// buffers bytes in a FIFO and counts breaks in the incrementing byte pattern.
module serial_byte_rx
  import spipass_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] TIMEOUT     = TIMEOUT_DEFAULT,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_in,
  input  logic              sdata_in,
  input  logic              cs_n_in,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              overflow,
  input  logic              clr,
  output logic [7:0]        seq_err_cnt,
  output logic              aligned
);

  localparam logic [2:0] PIN_IDLE = 3'b100;

  logic [2:0]                   pins;
  logic [SYNC_STAGES-1:0][2:0]  sync_q, sync_d;
  logic                         sclk_s, sdata_s, cs_n_s;
  logic                         sclk_prev_q;
  logic                         rise_q, rise_d, fall_q, fall_d;

  rx_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [15:0]       idle_cnt_q, idle_cnt_d;
  logic              first_q, first_d;
  logic [BYTE_W-1:0] last_byte_q, last_byte_d;
  logic [7:0]        seq_err_q, seq_err_d;
  logic              overflow_q, overflow_d;

  logic [BYTE_W-1:0] byte_w;
  logic              fifo_wr;
  logic              fifo_empty;
  logic              fifo_drop;
  logic              pop;

  assign pins = {cs_n_in, sdata_in, sclk_in};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_d[gi] = pins;
      end else begin : g_chain
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  assign sclk_s  = sync_q[SYNC_STAGES-1][0];
  assign sdata_s = sync_q[SYNC_STAGES-1][1];
  assign cs_n_s  = sync_q[SYNC_STAGES-1][2];
  assign rise_d  = sclk_s & ~sclk_prev_q;
  assign fall_d  = ~sclk_s & sclk_prev_q;
  assign byte_w  = {shreg_q[6:0], sdata_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    first_d     = first_q;
    last_byte_d = last_byte_q;
    seq_err_d   = seq_err_q;
    fifo_wr     = 1'b0;

    if (rise_q || fall_q) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TIMEOUT) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!cs_n_s && rise_q) begin
          state_d   = ST_RECV;
          bit_cnt_d = '0;
          first_d   = 1'b1;
        end
      end
      ST_RECV: begin
        // Leaving the frame drops any partial byte: bit_cnt restarts on re-entry.
        if (cs_n_s || (idle_cnt_q == TIMEOUT)) begin
          state_d = ST_IDLE;
        end else if (fall_q) begin
          shreg_d   = byte_w;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            fifo_wr     = 1'b1;
            first_d     = 1'b0;
            last_byte_d = byte_w;
            if (!first_q && (byte_w != last_byte_q + 8'd1) && (seq_err_q != 8'hFF)) begin
              seq_err_d = seq_err_q + 8'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr) begin
      seq_err_d = '0;
    end
    overflow_d = clr ? 1'b0 : (overflow_q | fifo_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= {SYNC_STAGES{PIN_IDLE}};
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      idle_cnt_q  <= '0;
      first_q     <= 1'b1;
      last_byte_q <= '0;
      seq_err_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_s;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      idle_cnt_q  <= idle_cnt_d;
      first_q     <= first_d;
      last_byte_q <= last_byte_d;
      seq_err_q   <= seq_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pop = !fifo_empty && byte_ready;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (byte_w),
    .rd_en   (pop),
    .rd_data (byte_data),
    .empty   (fifo_empty),
    .dropped (fifo_drop)
  );

  assign byte_valid  = !fifo_empty;
  assign overflow    = overflow_q;
  assign seq_err_cnt = seq_err_q;
  assign aligned     = (state_q == ST_RECV);

endmodule

// File: tb/tb_serial_byte_rx.sv
// Self-checking bench: table-driven byte vectors, hand-written corner sequences and
// a randomized ramp with random backpressure, checked against a queue-based model.
module tb_serial_byte_rx;

  localparam int          S     = 2;
  localparam logic [15:0] TO    = 16'd200;
  localparam int          DEPTH = 4;
  localparam int          HALF  = S + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       sdata = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic       overflow;
  logic       clr = 1'b0;
  logic [7:0] seq_err_cnt;
  logic       aligned;

  always #5 clk = ~clk;

  serial_byte_rx #(
    .SYNC_STAGES (S),
    .TIMEOUT     (TO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_in     (sclk),
    .sdata_in    (sdata),
    .cs_n_in     (cs_n),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .overflow    (overflow),
    .clr         (clr),
    .seq_err_cnt (seq_err_cnt),
    .aligned     (aligned)
  );

  int checks = 0;
  int errors = 0;

  // Model state: bytes expected out of the FIFO in order, plus sequence/overflow rules.
  logic [7:0] sent_q[$];
  int         rd_idx = 0;
  int         rdy_mode = 0;  // 0: never ready, 1: always ready, 2: random
  bit         m_first = 1'b1;
  logic [7:0] m_last = 8'h00;
  int         m_err = 0;
  int         m_ovf = 0;

  typedef struct {
    logic [7:0] tx;
    bit         nf;
    int         exp_err;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One clock step; samples DUT at the falling edge and scores any byte popped next edge.
  task automatic tick();
    @(negedge clk);
    case (rdy_mode)
      0:       byte_ready = 1'b0;
      1:       byte_ready = 1'b1;
      default: byte_ready = 1'($urandom_range(0, 1));
    endcase
    if (byte_valid && byte_ready) begin
      checks++;
      if (rd_idx >= sent_q.size()) begin
        errors++;
        $display("FAIL rx_unexpected: got %0h expected no byte", byte_data);
      end else if (byte_data != sent_q[rd_idx]) begin
        errors++;
        $display("FAIL rx_byte[%0d]: got %0h expected %0h", rd_idx, byte_data, sent_q[rd_idx]);
      end
      rd_idx++;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (sent_q.size() - rd_idx >= DEPTH) m_ovf = 1;
    else sent_q.push_back(b);
    if (m_first) m_first = 1'b0;
    else if (b != 8'(m_last + 8'd1) && m_err < 255) m_err++;
    m_last = b;
  endtask

  // Sends the top n bits of b; a full byte also updates the model and reports
  // how many clk cycles after the last falling edge byte_valid first rose.
  task automatic send_bits(input logic [7:0] b, input int n, output int lat);
    bit was_v;
    lat = -1;
    was_v = 1'b1;
    for (int i = 7; i > 7 - n; i--) begin
      sdata = b[i];
      sclk  = 1'b1;
      repeat (HALF) tick();
      sclk = 1'b0;
      if (i == 0) begin
        model_byte(b);
        was_v = byte_valid;
      end
      for (int k = 1; k <= HALF; k++) begin
        tick();
        if (i == 0 && lat < 0 && !was_v && byte_valid) lat = k;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int lat;
    send_bits(b, 8, lat);
  endtask

  task automatic new_frame();
    cs_n = 1'b1;
    repeat (8) tick();
    cs_n = 1'b0;
    repeat (8) tick();
    m_first = 1'b1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_err = 0;
    m_ovf = 0;
    tick();
  endtask

  initial begin
    int lat;
    logic [7:0] start;
    logic [7:0] b;

    tbl[0]  = '{8'h00, 1'b1, 0};
    tbl[1]  = '{8'h01, 1'b0, 0};
    tbl[2]  = '{8'h02, 1'b0, 0};
    tbl[3]  = '{8'h03, 1'b0, 0};
    tbl[4]  = '{8'h04, 1'b0, 0};
    tbl[5]  = '{8'h05, 1'b0, 0};
    tbl[6]  = '{8'h10, 1'b1, 0};
    tbl[7]  = '{8'h11, 1'b0, 0};
    tbl[8]  = '{8'h13, 1'b0, 1};
    tbl[9]  = '{8'h14, 1'b0, 1};
    tbl[10] = '{8'hFF, 1'b1, 1};
    tbl[11] = '{8'h00, 1'b0, 1};

    // Reset with pins toggling
    rdy_mode = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      sclk  = 1'($urandom_range(0, 1));
      sdata = 1'($urandom_range(0, 1));
      cs_n  = 1'($urandom_range(0, 1));
    end
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_seq_err", seq_err_cnt, 0);
    check("rst_aligned", aligned, 0);
    sclk = 1'b0;
    sdata = 1'b0;
    cs_n = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Table: ramp and sequence breaks, frames restarted where marked
    rdy_mode = 1;
    for (int r = 0; r < 12; r++) begin
      if (tbl[r].nf) new_frame();
      send_byte(tbl[r].tx);
      repeat (2) tick();
      check($sformatf("tbl%0d_seq_err", r), seq_err_cnt, tbl[r].exp_err);
      check($sformatf("tbl%0d_aligned", r), aligned, 1);
    end
    repeat (6) tick();
    check("tbl_all_rx", rd_idx, sent_q.size());

    // Overflow with consumer stalled, then clr
    new_frame();
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      send_bits(8'(8'h20 + i), 8, lat);
      if (i == 0) check("valid_latency", lat, S + 2);
    end
    repeat (4) tick();
    check("ovf_set", overflow, m_ovf);
    check("ovf_held_valid", byte_valid, 1);
    rdy_mode = 1;
    repeat (12) tick();
    check("ovf_drained", rd_idx, sent_q.size());
    check("ovf_sticky", overflow, 1);
    pulse_clr();
    check("clr_overflow", overflow, 0);
    check("clr_seq_err", seq_err_cnt, 0);

    // Timeout realignment after a 3-bit fragment
    new_frame();
    send_bits(8'hE0, 3, lat);
    check("to_aligned_mid", aligned, 1);
    repeat (int'(TO) + 10) tick();
    check("to_aligned_lost", aligned, 0);
    m_first = 1'b1;
    rdy_mode = 0;
    send_byte(8'hA5);
    repeat (2) tick();
    check("to_valid", byte_valid, 1);
    check("to_byte", byte_data, 8'hA5);
    rdy_mode = 1;
    repeat (4) tick();

    // cs_n deasserted after 5 bits
    send_bits(8'hC3, 5, lat);
    rdy_mode = 0;
    cs_n = 1'b1;
    repeat (8) tick();
    check("cs_aligned_lost", aligned, 0);
    check("cs_no_write", byte_valid, 0);
    cs_n = 1'b0;
    repeat (8) tick();
    m_first = 1'b1;
    send_byte(8'h3C);
    repeat (2) tick();
    check("cs_byte", byte_data, 8'h3C);
    check("cs_seq_err", seq_err_cnt, m_err);
    rdy_mode = 1;
    repeat (4) tick();

    // 256-byte ramp with random backpressure
    pulse_clr();
    new_frame();
    rdy_mode = 2;
    start = 8'($urandom);
    for (int i = 0; i < 256; i++) send_byte(8'(start + 8'(i)));
    rdy_mode = 1;
    repeat (10) tick();
    check("ramp_all_rx", rd_idx, sent_q.size());
    check("ramp_seq_err", seq_err_cnt, m_err);
    check("ramp_overflow", overflow, m_ovf);

    // Random bytes, some continuing the sequence
    new_frame();
    rdy_mode = 2;
    b = 8'($urandom);
    for (int i = 0; i < 12; i++) begin
      send_byte(b);
      b = ($urandom_range(0, 1) == 1) ? 8'(b + 8'd1) : 8'($urandom);
    end
    rdy_mode = 1;
    repeat (10) tick();
    check("rand_seq_err", seq_err_cnt, m_err);
    check("rand_all_rx", rd_idx, sent_q.size());
    check("final_empty", byte_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_byte_rx.md
# serial_byte_rx

Receive-side deserializer for the FPGA's slow serial byte stream: clock on one pin, data on a second pin, active-low frame select on a third. It oversamples all three pins in the system clock domain and shifts bits in MSB first. Completed bytes are pushed into a small FIFO with a valid/ready output port, and a sequence checker counts breaks in the expected incrementing byte pattern. It is the direct consumer of the bit-serial transmitter stage and is used for loopback and link bring-up on the iCE40 board.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchronizer (≥2).
- `TIMEOUT`, default 16'd50000: clk cycles without an sclk edge before bit alignment is discarded.
- `FIFO_DEPTH`, default 4: output FIFO entries (power of two, ≥2).
- `clk`, input, 1: system clock (SB_HFOSC domain). All logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `sclk_in`, input, 1: serial bit clock from the pin, asynchronous.
- `sdata_in`, input, 1: serial data, MSB first, launched on the sclk rising edge.
- `cs_n_in`, input, 1: frame select, active low. Holding it low permanently is legal.
- `byte_data`, output, 8: FIFO head byte.
- `byte_valid`, output, 1: FIFO not empty.
- `byte_ready`, input, 1: consumer accepts the head byte when `byte_valid && byte_ready`.
- `overflow`, output, 1: sticky. Set when a byte completes while the FIFO is full.
- `clr`, input, 1: synchronous pulse that clears `overflow` and `seq_err_cnt`.
- `seq_err_cnt`, output, 8: count of sequence breaks, saturating at 8'hFF.
- `aligned`, output, 1: receiver is inside a framed byte stream.

## Operation
- Synchronizers: each of the three pins passes through a `SYNC_STAGES` flop chain. Edge detection compares the last stage with one extra registered copy.
- Sampling: data is sampled on the synchronized sclk **falling** edge (mid-bit), because the transmitter changes data on the rising edge.
- FSM has two states, IDLE and RECV.
  - IDLE → RECV when synchronized `cs_n` is low and an sclk rising edge is seen. `bit_cnt` is cleared at this transition.
  - RECV → IDLE when synchronized `cs_n` goes high, or `idle_cnt` reaches `TIMEOUT`.
  - On leaving RECV, a partial byte is discarded and nothing is written to the FIFO.
- In RECV, each falling edge does `shreg <= {shreg[6:0], sdata}` and `bit_cnt <= bit_cnt + 1` (3-bit, wraps). When `bit_cnt` == 7 at that edge, `{shreg[6:0], sdata}` is written to the FIFO.
- `idle_cnt` clears on any sclk edge and increments otherwise, saturating at `TIMEOUT`.
- `aligned` is high exactly in RECV.
- Sequence checker: the first byte after entering RECV only loads `last_byte`. Each later byte increments `seq_err_cnt` when `byte != last_byte + 1` (mod 256); `last_byte` is always updated. Wrap FF → 00 is not an error.
- FIFO: a write while full is dropped and sets `overflow`. A pop happens on `byte_valid && byte_ready`. Write and pop in the same cycle while full: both occur, no overflow.
- `clr` takes priority over a same-cycle error or overflow event; the counter and flag end at 0.
- Reset values: `byte_valid`=0, `byte_data`=8'h00, `overflow`=0, `seq_err_cnt`=0, `aligned`=0, FSM=IDLE, FIFO empty, `bit_cnt`=0, `idle_cnt`=0.

## Timing
- Pin edge to detected edge: `SYNC_STAGES`+1 clk cycles.
- 8th-bit falling edge at pin to `byte_valid` high (FIFO previously empty): `SYNC_STAGES`+2 cycles.
- `byte_data` is registered and stable whenever `byte_valid` is high. After a pop, the next entry appears on the following cycle, with no bubble.
- sclk high and low phases must each be ≥ `SYNC_STAGES`+1 clk cycles. Faster input is unsupported and gives no guarantee.
- Reset mid-byte: everything returns to the reset values asynchronously. The first edges after release re-enter via IDLE.

## Structure
- Package `spipass_pkg`: `BYTE_W`=8, the FSM state enum, and the default `TIMEOUT`.
- Sub-module `sync_fifo` (parameter `DEPTH`, width 8): pointers with an extra wrap bit; full and empty derived from the pointers.
- The synchronizer is an inline generate loop, not a separate module.

## Test plan
- Reset: hold `rst_n`=0 with toggling pins → all outputs at reset values; then release and send bytes 0x00..0x05 with `cs_n`=0 → bytes 00..05 received in order, `seq_err_cnt`=0.
- Sequence break: send 10, 11, 13, 14 → `seq_err_cnt`=1. Send FF, 00 → no error.
- Overflow: `byte_ready`=0, send 5 bytes → first 4 held in order, `overflow`=1. Assert `clr` → `overflow`=0 and `seq_err_cnt`=0.
- Timeout realign: send 3 bits, stall sclk for `TIMEOUT`+10 cycles → `aligned`=0. Next 8 bits 0xA5 → `byte_data`=A5.
- `cs_n` deassert mid-byte after 5 bits → partial byte dropped and no write. Reassert, send 0x3C → 3C.
- Backpressure: toggle `byte_ready` randomly during a 256-byte ramp → all 256 bytes received, no loss, `seq_err_cnt`=0.
